// File: rtl/fregs_wb_ctrl_if.sv
// Write-back request bus between the FP result producers (FPU, LSU)
// and the FP register-file write-back controller.
interface fregs_wb_ctrl_if #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/fregs_wb_ctrl.sv
// FP register-file write-back controller: round-robin arbitration of the
// single write port plus a per-register busy scoreboard for hazard stalls.
module fregs_wb_ctrl #(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                reset,
    fregs_wb_ctrl_if.slave      req,
    input  logic                issue_set,
    input  logic [AW-1:0]       issue_rd,
    input  logic [AW-1:0]       chk_rs1,
    input  logic [AW-1:0]       chk_rs2,
    input  logic [AW-1:0]       chk_rd,
    output logic                busy_rs1,
    output logic                busy_rs2,
    output logic                busy_rd,
    output logic                wr_en,
    output logic [AW-1:0]       wr_rd,
    output logic [XLEN-1:0]     wr_data,
    output logic [5:0]          pending_cnt
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_rr;
    logic [NREG-1:0] r_busy;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_rd;
    logic [XLEN-1:0] r_wr_data;
    logic [5:0]      r_cnt;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_gidx;
    logic            w_hs;
    int              w_idx;
    logic [AW-1:0]   w_grd;
    logic [XLEN-1:0] w_gdata;
    logic [PW-1:0]   w_rr_nxt;
    logic            w_set;
    logic            w_clr;
    logic            w_inc;
    logic            w_dec;
    logic [NREG-1:0] w_busy_nxt;
    logic [5:0]      w_cnt_nxt;

    // Search starts at the rr pointer; the first valid requester wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_hs    = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_rr) + k) % NREQ;
            if (!w_hs && req.req_valid[w_idx]) begin
                w_hs           = 1'b1;
                w_gidx         = PW'(w_idx);
                w_grant[w_idx] = 1'b1;
            end
        end
    end

    assign req.req_ready = w_grant;

    assign w_grd   = req.req_rd[int'(w_gidx)*AW +: AW];
    assign w_gdata = req.req_data[int'(w_gidx)*XLEN +: XLEN];

    assign w_rr_nxt = (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + PW'(1);

    assign w_set = issue_set && (issue_rd != '0);
    assign w_clr = w_hs && (w_grd != '0);
    assign w_inc = w_set && !r_busy[issue_rd];
    assign w_dec = w_clr && r_busy[w_grd] &&
                   !(w_set && (issue_rd == w_grd));

    // Clear first, then set, so a same-edge set on the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[w_grd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_inc, w_dec})
            2'b10:   w_cnt_nxt = r_cnt + 6'd1;
            2'b01:   w_cnt_nxt = r_cnt - 6'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr      <= '0;
            r_busy    <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_hs) begin
                r_rr <= w_rr_nxt;
            end
            // f0 grants complete the handshake but never reach the file.
            if (w_clr) begin
                r_wr_en   <= 1'b1;
                r_wr_rd   <= w_grd;
                r_wr_data <= w_gdata;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign busy_rs1 = (chk_rs1 != '0) && r_busy[chk_rs1];
    assign busy_rs2 = (chk_rs2 != '0) && r_busy[chk_rs2];
    assign busy_rd  = (chk_rd  != '0) && r_busy[chk_rd];

    assign wr_en       = r_wr_en;
    assign wr_rd       = r_wr_rd;
    assign wr_data     = r_wr_data;
    assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_fregs_wb_ctrl.sv
// Bench for fregs_wb_ctrl: directed vector table followed by randomized
// traffic checked against a set-of-busy-registers reference model.
module tb_fregs_wb_ctrl;

    logic        clk;
    logic        reset;
    logic        issue_set;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        busy_rd;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [5:0]  pending_cnt;

    fregs_wb_ctrl_if #(.NREQ(2), .AW(5), .XLEN(32)) bus ();

    fregs_wb_ctrl #(.NREQ(2), .XLEN(32), .AW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus),
        .issue_set   (issue_set),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .busy_rd     (busy_rd),
        .wr_en       (wr_en),
        .wr_rd       (wr_rd),
        .wr_data     (wr_data),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        iset;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  crd;
        logic [1:0]  e_rdy;
        logic        e_b1;
        logic        e_b2;
        logic        e_bd;
        logic        e_wen;
        logic [4:0]  e_wrd;
        logic [31:0] e_wd;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tv[$];

    int npass;
    int ntot;

    function automatic vec_t mk(
        input int unsigned rst, v, rd0, d0, rd1, d1,
        input int unsigned iset, ird, rs1, rs2, crd,
        input int unsigned erdy, eb1, eb2, ebd,
        input int unsigned ewen, ewrd, ewd, ecnt
    );
        vec_t r;
        r.rst   = rst[0];
        r.v     = v[1:0];
        r.rd0   = rd0[4:0];
        r.d0    = d0;
        r.rd1   = rd1[4:0];
        r.d1    = d1;
        r.iset  = iset[0];
        r.ird   = ird[4:0];
        r.rs1   = rs1[4:0];
        r.rs2   = rs2[4:0];
        r.crd   = crd[4:0];
        r.e_rdy = erdy[1:0];
        r.e_b1  = eb1[0];
        r.e_b2  = eb2[0];
        r.e_bd  = ebd[0];
        r.e_wen = ewen[0];
        r.e_wrd = ewrd[4:0];
        r.e_wd  = ewd;
        r.e_cnt = ecnt[5:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t t);
        reset         = t.rst;
        bus.req_valid = t.v;
        bus.req_rd    = {t.rd1, t.rd0};
        bus.req_data  = {t.d1, t.d0};
        issue_set     = t.iset;
        issue_rd      = t.ird;
        chk_rs1       = t.rs1;
        chk_rs2       = t.rs2;
        chk_rd        = t.crd;
    endtask

    task automatic apply(input vec_t t, input int i);
        @(negedge clk);
        drive(t);
        #1;
        chk($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(t.e_rdy));
        chk($sformatf("v%0d busy_rs1", i), 32'(busy_rs1), 32'(t.e_b1));
        chk($sformatf("v%0d busy_rs2", i), 32'(busy_rs2), 32'(t.e_b2));
        chk($sformatf("v%0d busy_rd", i), 32'(busy_rd), 32'(t.e_bd));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(t.e_wen));
        chk($sformatf("v%0d wr_rd", i), 32'(wr_rd), 32'(t.e_wrd));
        chk($sformatf("v%0d wr_data", i), wr_data, t.e_wd);
        chk($sformatf("v%0d pending", i), 32'(pending_cnt), 32'(t.e_cnt));
    endtask

    // Reference model state: the set of registers awaiting a write-back.
    bit          m_busy [32];
    int          m_rr;
    bit          m_wen;
    logic [4:0]  m_wrd;
    logic [31:0] m_wd;
    int          m_cnt;
    int          g;
    bit          p_v  [2];
    logic [4:0]  p_rd [2];
    logic [31:0] p_d  [2];
    bit          r_rst;
    bit          r_set;
    logic [4:0]  r_ird;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_crd;
    logic [1:0]  e_rdy;

    initial begin
        npass = 0;
        ntot  = 0;
        drive(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_rd", 32'(wr_rd), 32'd0);
        chk("reset wr_data", wr_data, 32'd0);
        chk("reset pending", 32'(pending_cnt), 32'd0);

        tv.push_back(mk(0,0,0,0,0,0, 1,5,5,0,0, 0,0,0,0, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,5,0,0, 0,1,0,0, 0,0,0,1));
        tv.push_back(mk(0,1,5,'h3F800000,0,0, 0,0,5,0,0,
                        1,1,0,0, 1,5,'h3F800000,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,5,0,0, 0,0,0,0, 0,5,'h3F800000,0));
        tv.push_back(mk(0,2,0,0,0,'hDEADBEEF, 0,0,0,0,0,
                        2,0,0,0, 0,5,'h3F800000,0));
        tv.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0, 0,5,'h3F800000,0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,5,'h3F800000,0));
        tv.push_back(mk(0,0,0,0,0,0, 1,7,0,7,0, 0,0,0,0, 0,5,'h3F800000,1));
        tv.push_back(mk(0,1,7,'h11111111,0,0, 1,7,0,7,7,
                        1,0,1,1, 1,7,'h11111111,1));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,7,0, 0,0,1,0, 0,7,'h11111111,1));
        tv.push_back(mk(0,2,0,0,7,'h22222222, 0,0,0,7,0,
                        2,0,1,0, 1,7,'h22222222,0));
        tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        tv.push_back(mk(0,3,3,'hA0,4,'hB0, 0,0,0,0,0, 1,0,0,0, 1,3,'hA0,0));
        tv.push_back(mk(0,3,3,'hA0,4,'hB0, 0,0,0,0,0, 2,0,0,0, 1,4,'hB0,0));
        tv.push_back(mk(0,3,3,'hA0,4,'hB0, 0,0,0,0,0, 1,0,0,0, 1,3,'hA0,0));
        tv.push_back(mk(0,3,3,'hA0,4,'hB0, 0,0,0,0,0, 2,0,0,0, 1,4,'hB0,0));
        tv.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0, 0,0,0,0, 0,4,'hB0,1));
        tv.push_back(mk(0,0,0,0,0,0, 1,2,0,0,0, 0,0,0,0, 0,4,'hB0,2));
        tv.push_back(mk(0,0,0,0,0,0, 1,3,0,0,0, 0,0,0,0, 0,4,'hB0,3));
        tv.push_back(mk(0,1,9,'hC0,0,0, 0,0,0,0,0, 1,0,0,0, 1,9,'hC0,3));
        tv.push_back(mk(1,1,1,'hD0,0,0, 0,0,1,2,3, 1,1,1,1, 0,0,0,0));
        tv.push_back(mk(0,3,3,'hA0,4,'hB0, 0,0,1,2,3, 1,0,0,0, 1,3,'hA0,0));

        foreach (tv[i]) apply(tv[i], i);

        @(negedge clk);
        drive(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_rr  = 0;
        m_wen = 1'b0;
        m_wrd = '0;
        m_wd  = '0;
        for (int i = 0; i < 2; i++) p_v[i] = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 299) == 0);
            r_set = ($urandom_range(0, 2) == 0);
            r_ird = 5'($urandom_range(0, 9));
            r_rs1 = 5'($urandom_range(0, 9));
            r_rs2 = 5'($urandom_range(0, 9));
            r_crd = 5'($urandom_range(0, 9));
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && $urandom_range(0, 1) == 1) begin
                    p_v[i]  = 1'b1;
                    p_rd[i] = 5'($urandom_range(0, 9));
                    p_d[i]  = $urandom;
                end
            end
            reset         = r_rst;
            bus.req_valid = {p_v[1], p_v[0]};
            bus.req_rd    = {p_rd[1], p_rd[0]};
            bus.req_data  = {p_d[1], p_d[0]};
            issue_set     = r_set;
            issue_rd      = r_ird;
            chk_rs1       = r_rs1;
            chk_rs2       = r_rs2;
            chk_rd        = r_crd;

            if (p_v[0] && p_v[1]) g = m_rr;
            else if (p_v[0])      g = 0;
            else if (p_v[1])      g = 1;
            else                  g = -1;
            e_rdy = (g < 0) ? 2'b00 : 2'(1 << g);

            #1;
            chk("rnd ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("rnd busy_rs1", 32'(busy_rs1), 32'(m_busy[r_rs1]));
            chk("rnd busy_rs2", 32'(busy_rs2), 32'(m_busy[r_rs2]));
            chk("rnd busy_rd", 32'(busy_rd), 32'(m_busy[r_crd]));

            @(posedge clk);
            if (r_rst) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_rr  = 0;
                m_wen = 1'b0;
                m_wrd = '0;
                m_wd  = '0;
            end else begin
                m_wen = 1'b0;
                if (g >= 0) begin
                    m_rr = (g + 1) % 2;
                    if (p_rd[g] != 0) begin
                        m_busy[p_rd[g]] = 1'b0;
                        m_wen = 1'b1;
                        m_wrd = p_rd[g];
                        m_wd  = p_d[g];
                    end
                end
                if (r_set && r_ird != 0) m_busy[r_ird] = 1'b1;
            end
            m_cnt = 0;
            foreach (m_busy[i]) m_cnt += int'(m_busy[i]);
            if (g >= 0) p_v[g] = 1'b0;

            #1;
            chk("rnd wr_en", 32'(wr_en), 32'(m_wen));
            chk("rnd wr_rd", 32'(wr_rd), 32'(m_wrd));
            chk("rnd wr_data", wr_data, m_wd);
            chk("rnd pending", 32'(pending_cnt), 32'(m_cnt));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
